led_shift_arbiter: RTL and testbench

LED_SHIFT_ARBITER -- requirements
Module: led_shift_arbiter

---
 rtl/led_chain_pkg.sv | 19 +
 rtl/led_rr_pick.sv | 32 +++
 rtl/led_shift_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_led_shift_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_chain_pkg.sv
// Shared definitions for the LED serial-chain drivers.
//   led_state_e  : frame sequencer state encoding
//   half_cycles(): system-clock cycles per half period of the shift clock
package led_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIT_LO = 2'd1,
        ST_BIT_HI = 2'd2,
        ST_LATCH  = 2'd3
    } led_state_e;

    // Integer cycles per half bit period; 0 means the bit rate is too high.
    function automatic int unsigned half_cycles(input int unsigned sysclk_f,
                                                input int unsigned shift_hz);
        return sysclk_f / shift_hz / 2;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-requester request levels
//   ptr    : highest-priority index for this pick
//   winner : first requesting index at or after ptr, wrapping N_REQ-1 -> 0
//   valid  : at least one request is present
module led_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % int'(N_REQ));
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/led_shift_arbiter.sv
// Round-robin arbiter feeding a single serial LED shift chain.
//   sys_clk, rst : clock and asynchronous active-high reset
//   req          : per-requester frame request (level)
//   req_data     : requester i's word in [i*WORD_W +: WORD_W]
//   gnt          : one-hot pulse in the first cycle after a word is captured
//   busy         : frame in progress (grant through end of latch)
//   done         : one-cycle pulse when a frame completes
//   led_do       : serial data, LSB first, changes only with led_clk low
//   led_clk      : shift clock, device samples on rising edge
//   led_latch    : output-register strobe after the last bit
module led_shift_arbiter
    import led_chain_pkg::*;
#(
    parameter int unsigned SYSCLK_F = 12000000,
    parameter int unsigned SHIFT_HZ = 2000000,
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WORD_W   = 8
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic                      led_do,
    output logic                      led_clk,
    output logic                      led_latch
);

    localparam int unsigned HALF   = half_cycles(SYSCLK_F, SHIFT_HZ);
    localparam int unsigned PTR_W  = $clog2(N_REQ);
    localparam int unsigned HCNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BCNT_W = $clog2(WORD_W + 1);

    if (HALF < 1) begin : g_bad_half
        $error("led_shift_arbiter: SYSCLK_F/SHIFT_HZ/2 must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("led_shift_arbiter: N_REQ must be in 2..8");
    end

    led_state_e        state, state_d;
    logic [HCNT_W-1:0] half_cnt, half_d;
    logic [BCNT_W-1:0] bit_cnt, bit_d;
    logic [WORD_W-1:0] shreg, shreg_d;
    logic [PTR_W-1:0]  ptr, ptr_d;
    logic [PTR_W-1:0]  winner_q, winner_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              busy_d, done_d, led_do_d, led_clk_d, led_latch_d;

    logic [PTR_W-1:0]  pick;
    logic              pick_valid;
    logic              half_last_c;
    logic [BCNT_W-1:0] bit_inc_c;
    logic [WORD_W-1:0] shifted_c;
    logic [WORD_W-1:0] word_c;

    led_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign half_last_c = (half_cnt == HCNT_W'(HALF - 1));
    assign bit_inc_c   = bit_cnt + BCNT_W'(1);
    assign shifted_c   = shreg >> 1;
    assign word_c      = req_data[pick*WORD_W +: WORD_W];

    // State and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            winner_q  <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            led_do    <= 1'b0;
            led_clk   <= 1'b0;
            led_latch <= 1'b0;
        end else begin
            state     <= state_d;
            half_cnt  <= half_d;
            bit_cnt   <= bit_d;
            shreg     <= shreg_d;
            ptr       <= ptr_d;
            winner_q  <= winner_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            done      <= done_d;
            led_do    <= led_do_d;
            led_clk   <= led_clk_d;
            led_latch <= led_latch_d;
        end
    end

    // Next-state and next-output logic; output values are set on the
    // transition into each state so the registered pins match that state.
    always_comb begin
        state_d     = state;
        half_d      = half_cnt;
        bit_d       = bit_cnt;
        shreg_d     = shreg;
        ptr_d       = ptr;
        winner_d    = winner_q;
        gnt_d       = '0;
        busy_d      = busy;
        done_d      = 1'b0;
        led_do_d    = led_do;
        led_clk_d   = led_clk;
        led_latch_d = led_latch;

        unique case (state)
            ST_IDLE: begin
                busy_d      = 1'b0;
                led_clk_d   = 1'b0;
                led_latch_d = 1'b0;
                // The done cycle is a forced idle gap between frames.
                if (pick_valid && !done) begin
                    state_d  = ST_BIT_LO;
                    shreg_d  = word_c;
                    winner_d = pick;
                    gnt_d    = N_REQ'(1) << pick;
                    busy_d   = 1'b1;
                    led_do_d = word_c[0];
                    half_d   = '0;
                    bit_d    = '0;
                end
            end

            ST_BIT_LO: begin
                if (half_last_c) begin
                    state_d   = ST_BIT_HI;
                    half_d    = '0;
                    led_clk_d = 1'b1;
                end else begin
                    half_d = half_cnt + HCNT_W'(1);
                end
            end

            ST_BIT_HI: begin
                if (half_last_c) begin
                    half_d    = '0;
                    shreg_d   = shifted_c;
                    bit_d     = bit_inc_c;
                    led_clk_d = 1'b0;
                    if (bit_inc_c == BCNT_W'(WORD_W)) begin
                        state_d     = ST_LATCH;
                        led_latch_d = 1'b1;
                    end else begin
                        state_d  = ST_BIT_LO;
                        led_do_d = shifted_c[0];
                    end
                end else begin
                    half_d = half_cnt + HCNT_W'(1);
                end
            end

            ST_LATCH: begin
                if (half_last_c) begin
                    state_d     = ST_IDLE;
                    half_d      = '0;
                    led_latch_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    ptr_d       = (winner_q == PTR_W'(N_REQ - 1)) ? '0
                                                                  : winner_q + PTR_W'(1);
                end else begin
                    half_d = half_cnt + HCNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_shift_arbiter.sv
// Scoreboard bench for led_shift_arbiter with default parameters.
module tb_led_shift_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned WORD_W = 8;

    logic                    sys_clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    busy, done, led_do, led_clk, led_latch;

    always #5 sys_clk = ~sys_clk;

    led_shift_arbiter #(
        .SYSCLK_F (12000000),
        .SHIFT_HZ (2000000),
        .N_REQ    (N_REQ),
        .WORD_W   (WORD_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .led_do    (led_do),
        .led_clk   (led_clk),
        .led_latch (led_latch)
    );

    typedef struct {
        int         idx;
        logic [7:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, gnt_total = 0, done_total = 0, bits_seen = 0;
    int gnt_cyc = 0, last_rise = 0, last_done = -100;
    int latch_len = 0, do_stable = 0;
    logic in_frame = 1'b0, first_rise = 1'b1, prev_clk = 1'b0, prev_do = 1'b0;
    logic [7:0] word_seen = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    // Monitor: pops the expected frame at each grant and checks it at done.
    always @(negedge sys_clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 1'b0;
            prev_clk  = 1'b0;
            prev_do   = 1'b0;
            do_stable = 0;
        end else begin
            if (gnt != '0) begin
                gnt_total++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("gnt", 32'(gnt), 32'd1 << cur.idx);
                    chk("busy_at_gnt", 32'(busy), 32'd1);
                    chk("frame_gap", 32'((cyc - last_done) >= 2), 32'd1);
                    in_frame   = 1'b1;
                    bits_seen  = 0;
                    word_seen  = '0;
                    latch_len  = 0;
                    gnt_cyc    = cyc;
                    first_rise = 1'b1;
                end
            end
            if (led_do !== prev_do) begin
                do_stable = 0;
                chk("do_change_clk_low", 32'(led_clk), 32'd0);
            end else begin
                do_stable++;
            end
            if (led_clk && !prev_clk) begin
                if (bits_seen < 8) word_seen[bits_seen] = led_do;
                bits_seen++;
                chk("do_setup", 32'(do_stable >= 3), 32'd1);
                if (!first_rise) chk("rise_spacing", 32'(cyc - last_rise), 32'd6);
                first_rise = 1'b0;
                last_rise  = cyc;
            end
            if (led_latch) begin
                latch_len++;
                chk("clk_low_in_latch", 32'(led_clk), 32'd0);
                if (!in_frame) chk("stray_latch", 32'(led_latch), 32'd0);
            end
            if (done) begin
                done_total++;
                last_done = cyc;
                chk("done_in_frame", 32'(in_frame), 32'd1);
                if (in_frame) begin
                    chk("word", 32'(word_seen), 32'(cur.word));
                    chk("rise_count", 32'(bits_seen), 32'd8);
                    chk("latch_len", 32'(latch_len), 32'd3);
                    chk("frame_len", 32'(cyc - gnt_cyc), 32'd51);
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
                in_frame = 1'b0;
            end
            prev_clk = led_clk;
            prev_do  = led_do;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic expect_frame(input int idx);
        exp_t e;
        e.idx  = idx;
        e.word = req_data[idx*8 +: 8];
        exp_q.push_back(e);
    endtask

    task automatic wait_gnts(input int target);
        int budget = 3000;
        while (gnt_total < target && budget > 0) begin
            idle(1);
            budget--;
        end
        if (gnt_total < target) chk("gnt_timeout", 32'(gnt_total), 32'(target));
    endtask

    task automatic wait_dones(input int target);
        int budget = 3000;
        while (done_total < target && budget > 0) begin
            idle(1);
            budget--;
        end
        if (done_total < target) chk("done_timeout", 32'(done_total), 32'(target));
    endtask

    task automatic wait_bits(input int target);
        int budget = 200;
        while (bits_seen < target && budget > 0) begin
            idle(1);
            budget--;
        end
        if (bits_seen < target) chk("bits_timeout", 32'(bits_seen), 32'(target));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_do"},    32'(led_do),    32'd0);
        chk({tag, "_clk"},   32'(led_clk),   32'd0);
        chk({tag, "_latch"}, 32'(led_latch), 32'd0);
    endtask

    // Drive one burst of requests and wait for all expected frames.
    task automatic run_burst(input logic [N_REQ-1:0] r, input int n);
        int g0 = gnt_total;
        int d0 = done_total;
        req = r;
        wait_gnts(g0 + n);
        req = '0;
        wait_dones(d0 + n);
        idle(3);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        idle(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        req_data = {8'h96, 8'h5A, 8'hC3, 8'h3C};
        idle(2);

        // All requesting from ptr 0.
        expect_frame(0); expect_frame(1); expect_frame(2); expect_frame(3); expect_frame(0);
        run_burst(4'b1111, 5);

        // Two requesters starting from ptr 1.
        expect_frame(1); expect_frame(0); expect_frame(1); expect_frame(0);
        run_burst(4'b0011, 4);

        // Single request with a known bit pattern.
        req_data[7:0] = 8'hA5;
        expect_frame(0);
        run_burst(4'b0001, 1);

        // Word changes after grant must not affect the shifted data.
        req_data[23:16] = 8'h00;
        expect_frame(2);
        req = 4'b0100;
        wait_gnts(gnt_total + 1);
        req = '0;
        idle(10);
        req_data[23:16] = 8'hFF;
        wait_dones(done_total + 1);
        req_data[23:16] = 8'h5A;
        idle(3);

        // A request raised mid-frame and dropped before done is never granted.
        expect_frame(0);
        req = 4'b0001;
        wait_gnts(gnt_total + 1);
        req = 4'b0010;
        idle(5);
        req = '0;
        wait_dones(done_total + 1);
        idle(10);

        // Reset during the 4th high phase aborts the frame without a latch.
        expect_frame(1);
        req = 4'b0010;
        wait_gnts(gnt_total + 1);
        req = '0;
        wait_bits(4);
        chk("clk_high_before_rst", 32'(led_clk), 32'd1);
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_outputs_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("latch_during_rst", 32'(led_latch), 32'd0);
        end
        rst = 1'b0;
        expect_frame(2);
        run_burst(4'b0100, 1);

        // Reset in idle clears ptr (3 before reset): 1001 must pick 0.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        expect_frame(0);
        run_burst(4'b1001, 1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
